// File: rtl/piezo_alert_sched_if.sv
// rtl/piezo_alert_sched_if.sv - alert request / piezo drive bundle between status logic and the scheduler
//  master: alert sources driving moving/batt_low/ovr_spd and observing the drive outputs
//  slave : the scheduler, consuming requests and driving piezo/piezo_n/busy/tune_id
interface piezo_alert_sched_if;
  logic       moving;
  logic       batt_low;
  logic       ovr_spd;
  logic       piezo;
  logic       piezo_n;
  logic       busy;
  logic [1:0] tune_id;

  modport master (output moving, output batt_low, output ovr_spd,
                  input piezo, input piezo_n, input busy, input tune_id);
  modport slave  (input moving, input batt_low, input ovr_spd,
                  output piezo, output piezo_n, output busy, output tune_id);
endinterface

// File: rtl/piezo_alert_sched.sv
// rtl/piezo_alert_sched.sv - arbitrates three alert requesters onto one piezo and plays their tunes
//  clk      : system clock
//  rst_n    : asynchronous active-low reset
//  bus      : piezo_alert_sched_if.slave (moving, batt_low, ovr_spd in; piezo, piezo_n, busy, tune_id out)
//  FAST_SIM_EN (macro): when defined, note and gap lengths are divided by FAST_DIV; half-periods unchanged
module piezo_alert_sched #(
  parameter int NOTE_CLKS = 8388608,
  parameter int GAP_CLKS  = 134217728,
  parameter int FAST_DIV  = 64,
  parameter int HP_G6     = 15944,
  parameter int HP_C7     = 11945,
  parameter int HP_E7     = 9480,
  parameter int HP_G7     = 7972
) (
  input  logic clk,
  input  logic rst_n,
  piezo_alert_sched_if.slave bus
);

`ifdef FAST_SIM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int DIV      = FAST ? FAST_DIV : 1;
  localparam int NOTE_EFF = NOTE_CLKS / DIV;
  localparam int GAP_EFF  = GAP_CLKS / DIV;
  localparam int NW       = (NOTE_EFF > 1) ? $clog2(NOTE_EFF) : 1;
  localparam int GW       = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam int HP_MAX   = (HP_G6 > HP_C7 ? HP_G6 : HP_C7) > (HP_E7 > HP_G7 ? HP_E7 : HP_G7)
                            ? (HP_G6 > HP_C7 ? HP_G6 : HP_C7) : (HP_E7 > HP_G7 ? HP_E7 : HP_G7);
  localparam int HW       = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_EFF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_EFF - 1);
  localparam logic [HW-1:0] G6_LAST   = HW'(HP_G6 - 1);
  localparam logic [HW-1:0] C7_LAST   = HW'(HP_C7 - 1);
  localparam logic [HW-1:0] E7_LAST   = HW'(HP_E7 - 1);
  localparam logic [HW-1:0] G7_LAST   = HW'(HP_G7 - 1);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_NORM = 2'b01;
  localparam logic [1:0] T_BATT = 2'b10;
  localparam logic [1:0] T_OVR  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    tune_q;
  logic [2:0]    idx;
  logic [NW-1:0] note_cnt;
  logic [HW-1:0] hp_cnt;
  logic [GW-1:0] gap_cnt;
  logic          phase;
  logic [HW-1:0] hp_last;
  logic [2:0]    last_idx;
  logic [1:0]    req_id;

  // Fixed priority: over-speed beats battery beats motion.
  always_comb begin
    req_id = T_NONE;
    if (bus.ovr_spd)       req_id = T_OVR;
    else if (bus.batt_low) req_id = T_BATT;
    else if (bus.moving)   req_id = T_NORM;
  end

  // Note ROMs: half-period terminal count and last note index of the active tune.
  always_comb begin
    hp_last  = G6_LAST;
    last_idx = 3'd5;
    case (tune_q)
      T_NORM: begin
        last_idx = 3'd3;
        case (idx)
          3'd0:    hp_last = G6_LAST;
          3'd1:    hp_last = C7_LAST;
          3'd2:    hp_last = E7_LAST;
          default: hp_last = G7_LAST;
        endcase
      end
      T_BATT: begin
        last_idx = 3'd2;
        case (idx)
          3'd0:    hp_last = G7_LAST;
          3'd1:    hp_last = E7_LAST;
          default: hp_last = C7_LAST;
        endcase
      end
      default: hp_last = idx[0] ? G7_LAST : G6_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tune_q   <= T_NONE;
      idx      <= 3'd0;
      note_cnt <= '0;
      hp_cnt   <= '0;
      gap_cnt  <= '0;
      phase    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_id != T_NONE) begin
            state    <= S_PLAY;
            tune_q   <= req_id;
            idx      <= 3'd0;
            note_cnt <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b1;
          end
        end
        S_PLAY: begin
          if (note_cnt == NOTE_LAST) begin
            // Note boundary: every note starts high with fresh counters.
            note_cnt <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b1;
            if (bus.ovr_spd && tune_q != T_OVR) begin
              tune_q <= T_OVR;
              idx    <= 3'd0;
            end else if (idx == last_idx) begin
              idx <= 3'd0;
              if (tune_q == T_OVR) begin
                // Held over-speed loops the OVR tune with no silence in between.
                if (!bus.ovr_spd) begin
                  state  <= S_IDLE;
                  tune_q <= T_NONE;
                end
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            note_cnt <= note_cnt + 1'b1;
            if (hp_cnt == hp_last) begin
              hp_cnt <= '0;
              phase  <= ~phase;
            end else begin
              hp_cnt <= hp_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (bus.ovr_spd) begin
            state    <= S_PLAY;
            tune_q   <= T_OVR;
            idx      <= 3'd0;
            note_cnt <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state   <= S_IDLE;
            tune_q  <= T_NONE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset silences the pair immediately.
  assign bus.busy    = (state != S_IDLE);
  assign bus.piezo   = (state == S_PLAY) &&  phase;
  assign bus.piezo_n = (state == S_PLAY) && !phase;
  assign bus.tune_id = tune_q;

endmodule

// File: tb/tb_piezo_alert_sched.sv
// tb/tb_piezo_alert_sched.sv - self-checking bench for piezo_alert_sched
module tb_piezo_alert_sched;
`ifdef FAST_SIM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int FAST_DIV  = 64;
  localparam int DIV       = FAST ? FAST_DIV : 1;
  localparam int NOTE_N    = 256;
  localparam int GAP_N     = 512;
  localparam int NOTE_CLKS = NOTE_N * DIV;
  localparam int GAP_CLKS  = GAP_N * DIV;
  localparam int HP_G6     = 40;
  localparam int HP_C7     = 30;
  localparam int HP_E7     = 24;
  localparam int HP_G7     = 20;

  logic clk;
  logic rst_n;
  piezo_alert_sched_if bus ();

  piezo_alert_sched #(
    .NOTE_CLKS(NOTE_CLKS), .GAP_CLKS(GAP_CLKS), .FAST_DIV(FAST_DIV),
    .HP_G6(HP_G6), .HP_C7(HP_C7), .HP_E7(HP_E7), .HP_G7(HP_G7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;

  // Reference model: what is sounding, which note, how far into it.
  int m_mode;   // 0 silent/idle, 1 sounding, 2 post-tune silence
  int m_tune;
  int m_note;
  int m_t;
  int m_g;
  int rom_norm[4] = '{HP_G6, HP_C7, HP_E7, HP_G7};
  int rom_batt[3] = '{HP_G7, HP_E7, HP_C7};

  function automatic int tune_len(input int tune);
    return (tune == 1) ? 4 : (tune == 2) ? 3 : 6;
  endfunction

  function automatic int hp_of(input int tune, input int n);
    if (tune == 1) return rom_norm[n];
    if (tune == 2) return rom_batt[n];
    return (n % 2 == 1) ? HP_G7 : HP_G6;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tune = 0; m_note = 0; m_t = 0; m_g = 0;
  endtask

  task automatic model_step(input bit mv, input bit bl, input bit ov);
    case (m_mode)
      0: begin
        if (ov) m_tune = 3; else if (bl) m_tune = 2; else if (mv) m_tune = 1;
        if (ov || bl || mv) begin m_mode = 1; m_note = 0; m_t = 0; end
      end
      1: begin
        if (m_t == NOTE_N - 1) begin
          m_t = 0;
          if (ov && m_tune != 3) begin
            m_tune = 3; m_note = 0;
          end else if (m_note == tune_len(m_tune) - 1) begin
            m_note = 0;
            if (m_tune == 3) begin
              if (!ov) begin m_mode = 0; m_tune = 0; end
            end else begin
              m_mode = 2; m_g = 0;
            end
          end else begin
            m_note++;
          end
        end else begin
          m_t++;
        end
      end
      default: begin
        if (ov) begin m_mode = 1; m_tune = 3; m_note = 0; m_t = 0; end
        else if (m_g == GAP_N - 1) begin m_mode = 0; m_tune = 0; end
        else m_g++;
      end
    endcase
  endtask

  task automatic check_model();
    bit exp_p, exp_n, exp_b;
    exp_p = (m_mode == 1) && (((m_t / hp_of(m_tune, m_note)) % 2) == 0);
    exp_n = (m_mode == 1) && !exp_p;
    exp_b = (m_mode != 0);
    tests++;
    if (bus.piezo !== exp_p || bus.piezo_n !== exp_n || bus.busy !== exp_b ||
        bus.tune_id !== 2'(m_tune)) begin
      fails++;
      if (fails <= 10)
        $display("FAIL model_cycle @%0t: got piezo=%b piezo_n=%b busy=%b tune=%0d, expected %b %b %b %0d",
                 $time, bus.piezo, bus.piezo_n, bus.busy, bus.tune_id, exp_p, exp_n, exp_b, m_tune);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit mv, input bit bl, input bit ov);
    @(negedge clk);
    bus.moving = mv; bus.batt_low = bl; bus.ovr_spd = ov;
    @(posedge clk);
    model_step(mv, bl, ov);
    #1 check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.moving = 1'b0; bus.batt_low = 1'b0; bus.ovr_spd = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_state", {bus.piezo, bus.piezo_n, bus.busy, bus.tune_id}, 0);
    rst_n = 1'b1;
  endtask

  task automatic meas_high(input bit ov, output int w);
    w = 0;
    while (bus.piezo && w < 4 * NOTE_N) begin
      w++;
      cycle(1'b0, 1'b0, ov);
    end
  endtask

  typedef struct {
    bit mv; bit bl; bit ov;
    int tune; int busy;
  } arb_vec_t;
  arb_vec_t vecs[8];

  initial begin
    int w;
    int n;
    int cnt;
    bit rm, rb, ro;
    rst_n = 1'b0;
    bus.moving = 1'b0; bus.batt_low = 1'b0; bus.ovr_spd = 1'b0;
    model_reset();

    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 1};
    vecs[2] = '{0, 1, 0, 2, 1};
    vecs[3] = '{1, 1, 0, 2, 1};
    vecs[4] = '{0, 0, 1, 3, 1};
    vecs[5] = '{1, 0, 1, 3, 1};
    vecs[6] = '{0, 1, 1, 3, 1};
    vecs[7] = '{1, 1, 1, 3, 1};

    // Arbitration from IDLE.
    foreach (vecs[i]) begin
      do_reset();
      cycle(vecs[i].mv, vecs[i].bl, vecs[i].ov);
      chk("arb_tune", bus.tune_id, vecs[i].tune);
      chk("arb_busy", bus.busy, vecs[i].busy);
    end

    // Quiet with no requests.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (bus.piezo || bus.piezo_n || bus.busy || bus.tune_id != 2'b00) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // NORM: first half-period, then full span of notes plus gap.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    meas_high(1'b0, w);
    chk("norm_first_hp", w, HP_G6);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    n = 0;
    while (bus.busy && n < 4 * NOTE_N + GAP_N + 10) begin
      n++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    chk("norm_busy_span", n, 4 * NOTE_N + GAP_N);

    // Over-speed mid-note waits for the boundary, then loops without gaps.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.tune_id != 2'b11 && n < 2 * NOTE_N) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("preempt_latency", n, NOTE_N - 100);
    meas_high(1'b1, w);
    chk("ovr_first_hp", w, HP_G6);
    cnt = 0;
    for (int i = 0; i < 12 * NOTE_N; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (!bus.busy) cnt++;
    end
    chk("ovr_no_gap", cnt, 0);
    n = 0;
    while (bus.busy && n < 7 * NOTE_N) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("ovr_ends_idle", bus.busy, 0);

    // BATT, then over-speed aborts the gap.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    meas_high(1'b0, w);
    chk("batt_first_hp", w, HP_G7);
    n = 0;
    while (m_mode != 2 && n < 4 * NOTE_N) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("gap_silent", {bus.piezo, bus.piezo_n}, 0);
    chk("gap_busy", bus.busy, 1);
    chk("gap_tune", bus.tune_id, 2);
    cycle(1'b0, 1'b0, 1'b1);
    chk("gap_abort_tune", bus.tune_id, 3);
    chk("gap_abort_piezo", bus.piezo, 1);
    n = 0;
    while (bus.busy && n < 8 * NOTE_N) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end

    // Asynchronous reset mid-note, then restart with moving held.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {bus.piezo, bus.piezo_n, bus.busy, bus.tune_id}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.moving = 1'b1; bus.batt_low = 1'b0; bus.ovr_spd = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0);
    #1 check_model();
    chk("rst_restart_tune", bus.tune_id, 1);
    chk("rst_restart_piezo", bus.piezo, 1);

    // Random request traffic against the model.
    do_reset();
    rm = 1'b0; rb = 1'b0; ro = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 299) == 0) rm = ~rm;
      if ($urandom_range(0, 399) == 0) rb = ~rb;
      if ($urandom_range(0, 599) == 0) ro = ~ro;
      cycle(rm, rb, ro);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
